// File: rtl/opl_pkg.sv
// Shared widths and the elaboration-time 2^x mantissa table generator for the OPL
// log-to-linear converter.
package opl_pkg;
  localparam int FRAC_W = 8;
  localparam int MANT_W = 10;
  localparam int INT_W  = 4;
  localparam int LOG_W  = INT_W + FRAC_W;
  localparam int MAG_W  = MANT_W + 2;
  localparam int OUT_W  = MAG_W + 1;

  // Q30 fixed point keeps every product inside 64 bits.
  localparam int FX = 30;

  function automatic longint unsigned isqrt(input longint unsigned v);
    longint unsigned r, b, x;
    r = 0;
    x = v;
    b = 64'd1 << 62;
    for (int k = 0; k < 32; k++) begin
      if (x >= r + b) begin
        x = x - (r + b);
        r = (r >> 1) + b;
      end else begin
        r = r >> 1;
      end
      b = b >> 2;
    end
    return r;
  endfunction

  // round(2^(i/2^frac_w) * 2^mant_w) - 2^mant_w, built from repeated square roots of 2.
  function automatic int exp_rom_val(input int i, input int frac_w = FRAC_W,
                                     input int mant_w = MANT_W);
    longint unsigned root, acc;
    root = 64'd2 << FX;
    acc  = 64'd1 << FX;
    for (int k = 1; k <= frac_w; k++) begin
      root = isqrt(root << FX);
      if (i[frac_w-k]) acc = (acc * root) >> FX;
    end
    return int'((acc + (64'd1 << (FX - mant_w - 1))) >> (FX - mant_w)) - (1 << mant_w);
  endfunction
endpackage

// File: rtl/opl_exp_rom.sv
// Synchronous exponent ROM; contents are constants generated at elaboration.
module opl_exp_rom
  import opl_pkg::exp_rom_val;
#(
  parameter int FRAC_W = opl_pkg::FRAC_W,
  parameter int MANT_W = opl_pkg::MANT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [FRAC_W-1:0] addr,
  output logic [MANT_W-1:0] data
);
  logic [MANT_W-1:0] tbl [2**FRAC_W];

  for (genvar i = 0; i < 2**FRAC_W; i++) begin : g_rom
    assign tbl[i] = MANT_W'(exp_rom_val(i, FRAC_W, MANT_W));
  end

  always_ff @(posedge clk) begin
    if (rst)     data <= '0;
    else if (en) data <= tbl[addr];
  end
endmodule

// File: rtl/opl_exp_conv.sv
// Three-stage log-to-linear converter: address/latch, ROM read, shift+sign.
// Elastic valid/ready pipeline; bubbles collapse, stalls hold the output stable.
module opl_exp_conv #(
  parameter int FRAC_W   = opl_pkg::FRAC_W,
  parameter int MANT_W   = opl_pkg::MANT_W,
  parameter int INT_W    = opl_pkg::INT_W,
  parameter int TAG_W    = 5,
  parameter int NEG_MODE = 1,
  localparam int LOG_W   = INT_W + FRAC_W,
  localparam int MAG_W   = MANT_W + 2,
  localparam int OUT_W   = MAG_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [LOG_W-1:0] in_atten,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);
  localparam int STAGES = 3;

  typedef struct packed {
    logic             sign;
    logic [INT_W-1:0] sh;
    logic [TAG_W-1:0] tag;
  } ctl_t;

  logic [STAGES:1]   vld_pipe;
  logic              adv1, adv2, adv3;
  ctl_t              c1, c2;
  logic [FRAC_W-1:0] addr1;
  logic [MANT_W-1:0] rom_q;
  logic [MAG_W-1:0]  full, mag;
  logic [OUT_W-1:0]  ext, sv;

  // Each stage loads when empty or when its successor moves on.
  assign adv3      = out_ready | ~vld_pipe[3];
  assign adv2      = adv3 | ~vld_pipe[2];
  assign adv1      = adv2 | ~vld_pipe[1];
  assign in_ready  = adv1;
  assign out_valid = vld_pipe[3];

  opl_exp_rom #(.FRAC_W(FRAC_W), .MANT_W(MANT_W)) u_rom (
    .clk  (clk),
    .rst  (rst),
    .en   (adv2 & vld_pipe[1]),
    .addr (addr1),
    .data (rom_q)
  );

  // Hidden bit restored, then one bit of headroom before the attenuation shift.
  always_comb begin
    full = {1'b1, rom_q, 1'b0};
    mag  = (32'(c2.sh) >= MAG_W) ? '0 : (full >> c2.sh);
    ext  = {1'b0, mag};
    sv   = ext;
    if (c2.sign) sv = (NEG_MODE != 0) ? ~ext : -ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      c1       <= '0;
      c2       <= '0;
      addr1    <= '0;
      out_data <= '0;
      out_tag  <= '0;
    end else begin
      if (adv1) vld_pipe[1] <= in_valid;
      if (adv2) vld_pipe[2] <= vld_pipe[1];
      if (adv3) vld_pipe[3] <= vld_pipe[2];
      if (adv1 && in_valid) begin
        c1    <= '{sign: in_sign, sh: in_atten[LOG_W-1:FRAC_W], tag: in_tag};
        addr1 <= ~in_atten[FRAC_W-1:0];
      end
      if (adv2 && vld_pipe[1]) c2 <= c1;
      if (adv3 && vld_pipe[2]) begin
        out_data <= sv;
        out_tag  <= c2.tag;
      end
    end
  end
endmodule

// File: tb/tb_opl_exp_conv.sv
// Bench for opl_exp_conv: fixed vector table, handshake corner sequences, and an
// exhaustive randomized-flow sweep against a real-arithmetic reference model.
module tb_opl_exp_conv;
  localparam int TAG_W = 5;
  localparam int NEG   = 1;
  localparam int LOG_W = 12;
  localparam int OUT_W = 13;

  logic             clk = 1'b0, rst = 1'b1;
  logic             in_valid = 1'b0, in_ready, in_sign = 1'b0;
  logic [LOG_W-1:0] in_atten = '0;
  logic [TAG_W-1:0] in_tag = '0, out_tag;
  logic             out_valid, out_ready = 1'b1;
  logic [OUT_W-1:0] out_data;

  opl_exp_conv #(.TAG_W(TAG_W), .NEG_MODE(NEG)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_atten(in_atten), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic [TAG_W-1:0] tag;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit          s;
    logic [11:0] at;
    int          exp;
  } vec_t;
  vec_t tbl[9];

  bit               held = 0, acc = 0, oacc = 0;
  logic [OUT_W-1:0] hdata = '0;
  logic [TAG_W-1:0] htag = '0;
  int               nout = 0, nin = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Reference: 2^x evaluated in real arithmetic straight from the table definition.
  function automatic logic [OUT_W-1:0] ref_model(input bit s, input logic [11:0] at);
    int  fr, sh, m, mag, v;
    real x;
    fr  = int'(at[7:0]);
    sh  = int'(at[11:8]);
    x   = $pow(2.0, real'(255 - fr) / 256.0) * 1024.0;
    m   = $rtoi(x + 0.5);
    mag = (sh >= 12) ? 0 : (m * 2) / (1 << sh);
    v   = s ? ((NEG != 0) ? -mag - 1 : -mag) : mag;
    return v[OUT_W-1:0];
  endfunction

  // One clock: score handshakes at the falling edge, then move past the rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    acc  = 0;
    oacc = 0;
    if (!rst) begin
      if (held) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hdata);
        chk("hold_tag", out_tag, htag);
      end
      if (out_valid && out_ready) begin
        oacc = 1;
        nout++;
        chk("out_has_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_tag", out_tag, e.tag);
        end
      end
      if (in_valid && in_ready) begin
        acc = 1;
        nin++;
        sb.push_back('{data: ref_model(in_sign, in_atten), tag: in_tag});
      end
      held  = out_valid && !out_ready;
      hdata = out_data;
      htag  = out_tag;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    in_valid  = 0;
    out_ready = 1;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      step();
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int lat, k, cyc, a0, o0, idx;

    tbl[0] = '{0, 12'h000, 4084};
    tbl[1] = '{0, 12'h0FF, 2048};
    tbl[2] = '{0, 12'h100, 2042};
    tbl[3] = '{0, 12'hB00, 1};
    tbl[4] = '{0, 12'hC00, 0};
    tbl[5] = '{1, 12'h000, (NEG != 0) ? -4085 : -4084};
    tbl[6] = '{0, 12'h1FF, 1024};
    tbl[7] = '{0, 12'hFFF, 0};
    tbl[8] = '{1, 12'hC00, (NEG != 0) ? -1 : 0};

    // Reset state
    rst = 1;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 0;

    // Single-word vectors: value and latency
    for (int i = 0; i < 9; i++) begin
      in_valid = 1;
      in_sign  = tbl[i].s;
      in_atten = tbl[i].at;
      in_tag   = TAG_W'(i);
      out_ready = 1;
      chk("tbl_in_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 0;
      lat = 1;
      while (!out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
      chk("tbl_latency", lat, 3);
      chk("tbl_data", out_data, tbl[i].exp[OUT_W-1:0]);
      chk("tbl_tag", out_tag, i);
      @(posedge clk); #1;
    end
    chk("tbl_idle", out_valid, 0);

    // 16-word stream, out_ready toggling 1010...
    held = 0;
    o0 = nout;
    k = 0;
    cyc = 0;
    while ((k < 16 || sb.size() > 0) && cyc < 200) begin
      out_ready = (cyc % 2 == 0);
      in_valid  = (k < 16);
      in_sign   = 1'($urandom);
      in_atten  = 12'($urandom);
      in_tag    = TAG_W'(k);
      step();
      if (acc) k++;
      cyc++;
    end
    chk("stream_accepted", k, 16);
    chk("stream_outputs", nout - o0, 16);
    drain();

    // Fill with out_ready low: exactly 3 accepts, then steady 1 word/cycle
    out_ready = 0;
    in_valid  = 1;
    a0 = nin;
    for (int i = 0; i < 5; i++) begin
      in_atten = 12'($urandom);
      in_tag   = TAG_W'(20 + i);
      step();
    end
    chk("fill_accepts", nin - a0, 3);
    chk("fill_in_ready", in_ready, 0);
    out_ready = 1;
    a0 = nin;
    o0 = nout;
    for (int i = 0; i < 10; i++) begin
      in_atten = 12'($urandom);
      in_tag   = TAG_W'(i);
      step();
    end
    chk("steady_accepts", nin - a0, 10);
    chk("steady_outputs", nout - o0, 10);
    drain();

    // Reset with two words in flight
    out_ready = 0;
    in_valid  = 1;
    in_atten  = 12'h000;
    in_tag    = 5'd7;
    step();
    in_tag = 5'd8;
    step();
    in_valid = 0;
    rst = 1;
    @(posedge clk); #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    rst = 0;
    sb.delete();
    held = 0;
    out_ready = 1;
    o0 = nout;
    repeat (6) step();
    chk("midrst_no_output", nout - o0, 0);

    // Exhaustive atten x sign with random gaps and backpressure
    idx = 0;
    cyc = 0;
    while (idx < 8192 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_sign   = (idx >= 4096);
      in_atten  = idx[11:0];
      in_tag    = TAG_W'($urandom);
      step();
      if (acc) idx++;
      cyc++;
    end
    chk("exh_all_accepted", idx, 8192);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
